// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl_pkg
// Purpose  : Shared definitions for the hazard/stall controller, the decode
//            stage and the register file. Provides the register address
//            width, the hardwired-zero register index, the stall/flush
//            counter width and the controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 31;

  // Wide enough for LOAD_STALL_CYCLES - 1 up to 14.
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    FLUSH_ST = 2'd2
  } state_t;

endpackage : hazard_stall_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl_if
// Purpose  : Bundle of the decode/EX/MEM hazard sources and the front-end
//            control outputs (stall_enable, PC_HOLD, BUBBLE, FLUSH).
//   master : the hazard controller (reads sources, drives controls)
//   slave  : the pipeline side (drives sources, reads controls)
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_stall_ctrl_if;
  import hazard_stall_ctrl_pkg::*;

  logic                  ID_VALID;
  logic [REG_ADDR_W-1:0] ID_RN;
  logic [REG_ADDR_W-1:0] ID_RM;
  logic                  ID_USES_RM;
  logic                  EX_MEM_READ;
  logic [REG_ADDR_W-1:0] EX_RD;
  logic                  BRANCH_TAKEN;
  logic                  stall_enable;
  logic                  PC_HOLD;
  logic                  BUBBLE;
  logic                  FLUSH;

  modport master (
    input  ID_VALID, ID_RN, ID_RM, ID_USES_RM, EX_MEM_READ, EX_RD, BRANCH_TAKEN,
    output stall_enable, PC_HOLD, BUBBLE, FLUSH
  );

  modport slave (
    output ID_VALID, ID_RN, ID_RM, ID_USES_RM, EX_MEM_READ, EX_RD, BRANCH_TAKEN,
    input  stall_enable, PC_HOLD, BUBBLE, FLUSH
  );

endinterface : hazard_stall_ctrl_if
`default_nettype wire

// File: rtl/hazard_stall_ctrl_compare.sv
`default_nettype none
// ============================================================================
// Module   : hazard_compare
// Purpose  : Purely combinational load-use hazard equation. Also reused by
//            the forwarding unit, so it carries no state.
// Ports    : id_valid, id_rn, id_rm, id_uses_rm  - decode-stage fields
//            ex_mem_read, ex_rd                  - EX-stage load/destination
//            hazard                              - load-use hazard present
// Revision : 1.0 - initial release
// ============================================================================
module hazard_compare #(
  parameter int ZERO_REG = hazard_stall_ctrl_pkg::ZERO_REG
) (
  input  wire logic                                         id_valid,
  input  wire logic [hazard_stall_ctrl_pkg::REG_ADDR_W-1:0] id_rn,
  input  wire logic [hazard_stall_ctrl_pkg::REG_ADDR_W-1:0] id_rm,
  input  wire logic                                         id_uses_rm,
  input  wire logic                                         ex_mem_read,
  input  wire logic [hazard_stall_ctrl_pkg::REG_ADDR_W-1:0] ex_rd,
  output logic                                              hazard
);
  import hazard_stall_ctrl_pkg::*;

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  // The zero register never carries a real value, so a load to it cannot
  // create a dependency.
  assign hazard = id_valid & ex_mem_read & (ex_rd != ZERO_ADDR) &
                  ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));

endmodule : hazard_compare
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Load-use stall and taken-branch flush controller for the
//            IF/ID / ID/EX boundary. A three-state FSM (RUN/STALL/FLUSH_ST)
//            with a down-counter stretches stalls to LOAD_STALL_CYCLES and
//            flushes to FLUSH_CYCLES. A taken branch overrides everything.
// Ports    : CLK, RESET (async, active-high)
//            bus (master) - hazard sources in, stall/flush controls out
//            STALL_COUNT, FLUSH_COUNT - only with HAZARD_STATS_EN defined
// Options  : HAZARD_STATS_EN - saturating stall/flush cycle counters plus a
//            simulation message on each STALL entry.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int ZERO_REG          = hazard_stall_ctrl_pkg::ZERO_REG
) (
  input  wire logic           CLK,
  input  wire logic           RESET,
  hazard_stall_ctrl_if.master bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]         STALL_COUNT,
  output logic [15:0]         FLUSH_COUNT
`endif
);
  import hazard_stall_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             hazard;
  logic             stall_grp;
  logic             flush;

  hazard_compare #(
    .ZERO_REG (ZERO_REG)
  ) u_compare (
    .id_valid    (bus.ID_VALID),
    .id_rn       (bus.ID_RN),
    .id_rm       (bus.ID_RM),
    .id_uses_rm  (bus.ID_USES_RM),
    .ex_mem_read (bus.EX_MEM_READ),
    .ex_rd       (bus.EX_RD),
    .hazard      (hazard)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    stall_grp  = 1'b0;
    flush      = 1'b0;

    if (bus.BRANCH_TAKEN) begin
      // The hazarding instruction is being squashed, so any pending stall
      // is dropped and the flush window (re)starts here.
      flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        next_state = FLUSH_ST;
        next_cnt   = FLUSH_RELOAD;
      end else begin
        next_state = RUN;
        next_cnt   = '0;
      end
    end else begin
      case (state)
        RUN: begin
          // Mealy: the stall is raised in the detection cycle itself.
          stall_grp = hazard;
          if (hazard && (LOAD_STALL_CYCLES > 1)) begin
            next_state = STALL;
            next_cnt   = STALL_RELOAD;
          end
        end
        STALL: begin
          stall_grp = 1'b1;
          next_cnt  = cnt - 1'b1;
          if (cnt <= 1) begin
            next_state = RUN;
            next_cnt   = '0;
          end
        end
        FLUSH_ST: begin
          flush    = 1'b1;
          next_cnt = cnt - 1'b1;
          if (cnt <= 1) begin
            next_state = RUN;
            next_cnt   = '0;
          end
        end
        default: begin
          next_state = RUN;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs drop the instant RESET rises, without waiting for a clock edge.
  assign bus.stall_enable = stall_grp & ~RESET;
  assign bus.PC_HOLD      = stall_grp & ~RESET;
  assign bus.BUBBLE       = stall_grp & ~RESET;
  assign bus.FLUSH        = flush     & ~RESET;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STALL_COUNT <= '0;
      FLUSH_COUNT <= '0;
    end else begin
      if (stall_grp && (STALL_COUNT != 16'hFFFF)) STALL_COUNT <= STALL_COUNT + 16'd1;
      if (flush && (FLUSH_COUNT != 16'hFFFF))     FLUSH_COUNT <= FLUSH_COUNT + 16'd1;
      if ((state == RUN) && (next_state == STALL))
        $display("hazard_stall_ctrl: STALL entry at %0t", $time);
    end
  end
`endif

endmodule : hazard_stall_ctrl
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Self-checking bench. Two controllers share one stimulus stream:
//            dut_a (LOAD_STALL_CYCLES=1, FLUSH_CYCLES=2) and
//            dut_b (LOAD_STALL_CYCLES=3, FLUSH_CYCLES=1).
//            Expected outputs per step are queued and compared mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  logic CLK;
  logic RESET;

  hazard_stall_ctrl_if ifa ();
  hazard_stall_ctrl_if ifb ();

`ifdef HAZARD_STATS_EN
  logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

  hazard_stall_ctrl #(
    .LOAD_STALL_CYCLES (1),
    .FLUSH_CYCLES      (2),
    .ZERO_REG          (31)
  ) dut_a (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (ifa)
`ifdef HAZARD_STATS_EN
    ,
    .STALL_COUNT (a_stall_cnt),
    .FLUSH_COUNT (a_flush_cnt)
`endif
  );

  hazard_stall_ctrl #(
    .LOAD_STALL_CYCLES (3),
    .FLUSH_CYCLES      (1),
    .ZERO_REG          (31)
  ) dut_b (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (ifb)
`ifdef HAZARD_STATS_EN
    ,
    .STALL_COUNT (b_stall_cnt),
    .FLUSH_COUNT (b_flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string tag;
    logic  a_stall;
    logic  a_flush;
    logic  b_stall;
    logic  b_flush;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic um, input logic ld, input logic [4:0] rd,
                       input logic br);
    ifa.ID_VALID = v;  ifa.ID_RN = rn; ifa.ID_RM = rm; ifa.ID_USES_RM = um;
    ifa.EX_MEM_READ = ld; ifa.EX_RD = rd; ifa.BRANCH_TAKEN = br;
    ifb.ID_VALID = v;  ifb.ID_RN = rn; ifb.ID_RM = rm; ifb.ID_USES_RM = um;
    ifb.EX_MEM_READ = ld; ifb.EX_RD = rd; ifb.BRANCH_TAKEN = br;
  endtask

  task automatic compare();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end else begin
      e = q.pop_front();
      chk({e.tag, ".a_stall_enable"}, 16'(ifa.stall_enable), 16'(e.a_stall));
      chk({e.tag, ".a_pc_hold"},      16'(ifa.PC_HOLD),      16'(e.a_stall));
      chk({e.tag, ".a_bubble"},       16'(ifa.BUBBLE),       16'(e.a_stall));
      chk({e.tag, ".a_flush"},        16'(ifa.FLUSH),        16'(e.a_flush));
      chk({e.tag, ".b_stall_enable"}, 16'(ifb.stall_enable), 16'(e.b_stall));
      chk({e.tag, ".b_pc_hold"},      16'(ifb.PC_HOLD),      16'(e.b_stall));
      chk({e.tag, ".b_bubble"},       16'(ifb.BUBBLE),       16'(e.b_stall));
      chk({e.tag, ".b_flush"},        16'(ifb.FLUSH),        16'(e.b_flush));
    end
  endtask

  // Apply inputs just after a rising edge, check at the falling edge, then
  // advance past the next rising edge.
  task automatic step(input string tag, input logic v, input logic [4:0] rn,
                      input logic [4:0] rm, input logic um, input logic ld,
                      input logic [4:0] rd, input logic br,
                      input logic as_, input logic af, input logic bs, input logic bf);
    exp_t e;
    drive(v, rn, rm, um, ld, rd, br);
    e.tag = tag; e.a_stall = as_; e.a_flush = af; e.b_stall = bs; e.b_flush = bf;
    q.push_back(e);
    @(negedge CLK);
    compare();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_now(input string tag, input logic as_, input logic af,
                            input logic bs, input logic bf);
    exp_t e;
    e.tag = tag; e.a_stall = as_; e.a_flush = af; e.b_stall = bs; e.b_flush = bf;
    q.push_back(e);
    #1;
    compare();
  endtask

  // Shorthands for the common input patterns.
  task automatic idle(input string tag, input logic as_, input logic af,
                      input logic bs, input logic bf);
    step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, as_, af, bs, bf);
  endtask

  task automatic lu_rn3(input string tag, input logic br, input logic as_, input logic af,
                        input logic bs, input logic bf);
    step(tag, 1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, br, as_, af, bs, bf);
  endtask

  initial begin
    RESET = 1'b1;
    drive(1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    #2;
    expect_now("reset_hazard_inputs", 0, 0, 0, 0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    expect_now("reset_idle", 0, 0, 0, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Load-use on RN: one cycle for A, three cycles for B.
    idle  ("run_idle", 0, 0, 0, 0);
    lu_rn3("lu_rn_c1", 1'b0, 1, 0, 1, 0);
    idle  ("lu_rn_c2", 0, 0, 1, 0);
    idle  ("lu_rn_c3", 0, 0, 1, 0);
    idle  ("lu_rn_end", 0, 0, 0, 0);

    // Load-use on RM, inputs present one cycle only.
    step("lu_rm_c1", 1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1, 0, 1, 0);
    idle("lu_rm_c2", 0, 0, 1, 0);
    idle("lu_rm_c3", 0, 0, 1, 0);
    idle("lu_rm_end", 0, 0, 0, 0);

    // Conditions that must never stall.
    step("zero_reg",  1'b1, 5'd31, 5'd0, 1'b0, 1'b1, 5'd31, 1'b0, 0, 0, 0, 0);
    step("rm_unused", 1'b1, 5'd0,  5'd4, 1'b0, 1'b1, 5'd4,  1'b0, 0, 0, 0, 0);
    step("not_valid", 1'b0, 5'd3,  5'd0, 1'b0, 1'b1, 5'd3,  1'b0, 0, 0, 0, 0);
    step("no_load",   1'b1, 5'd3,  5'd0, 1'b0, 1'b0, 5'd3,  1'b0, 0, 0, 0, 0);

    // Hazard held: back-to-back stalls, re-detected on RUN re-entry.
    lu_rn3("b2b_c1", 1'b0, 1, 0, 1, 0);
    lu_rn3("b2b_c2", 1'b0, 1, 0, 1, 0);
    lu_rn3("b2b_c3", 1'b0, 1, 0, 1, 0);
    lu_rn3("b2b_c4", 1'b0, 1, 0, 1, 0);
    idle  ("b2b_c5", 0, 0, 1, 0);
    idle  ("b2b_c6", 0, 0, 1, 0);
    idle  ("b2b_end", 0, 0, 0, 0);

    // Taken branch in B's second stall cycle aborts the stall.
    lu_rn3("br_stall_c1", 1'b0, 1, 0, 1, 0);
    step  ("br_stall_c2", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 0, 1, 0, 1);
    idle  ("br_stall_c3", 0, 1, 0, 0);
    idle  ("br_stall_end", 0, 0, 0, 0);

    // Branch coincident with a hazard: branch wins.
    lu_rn3("br_hz_c1", 1'b1, 0, 1, 0, 1);
    lu_rn3("br_hz_c2", 1'b0, 0, 1, 1, 0);
    idle  ("br_hz_c3", 0, 0, 1, 0);
    idle  ("br_hz_c4", 0, 0, 1, 0);
    idle  ("br_hz_end", 0, 0, 0, 0);

    // Repeated branch reloads A's flush window.
    step("reload_c1", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 0, 1, 0, 1);
    step("reload_c2", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 0, 1, 0, 1);
    idle("reload_c3", 0, 1, 0, 0);
    idle("reload_end", 0, 0, 0, 0);

    // Asynchronous reset in the middle of B's stall.
    lu_rn3("rst_stall_c1", 1'b0, 1, 0, 1, 0);
    RESET = 1'b1;
    expect_now("rst_mid_stall", 0, 0, 0, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle("rst_stall_after", 0, 0, 0, 0);

    // Asynchronous reset in the middle of A's flush.
    step("rst_flush_c1", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 0, 1, 0, 1);
    RESET = 1'b1;
    expect_now("rst_mid_flush", 0, 0, 0, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;

`ifdef HAZARD_STATS_EN
    chk("stats_reset_a_stall", a_stall_cnt, 16'd0);
    chk("stats_reset_b_flush", b_flush_cnt, 16'd0);
`endif
    // Two stalls and one flush from a fresh reset.
    lu_rn3("st_c1", 1'b0, 1, 0, 1, 0);
    idle  ("st_c2", 0, 0, 1, 0);
    idle  ("st_c3", 0, 0, 1, 0);
    idle  ("st_c4", 0, 0, 0, 0);
    lu_rn3("st_c5", 1'b0, 1, 0, 1, 0);
    idle  ("st_c6", 0, 0, 1, 0);
    idle  ("st_c7", 0, 0, 1, 0);
    step  ("st_c8", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 0, 1, 0, 1);
    idle  ("st_c9", 0, 1, 0, 0);
    idle  ("st_end", 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    chk("stats_b_stall", b_stall_cnt, 16'd6);
    chk("stats_b_flush", b_flush_cnt, 16'd1);
    chk("stats_a_stall", a_stall_cnt, 16'd2);
    chk("stats_a_flush", a_flush_cnt, 16'd2);
`endif

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d entries expected=0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hazard_stall_ctrl
`default_nettype wire
